// File: rtl/otf_quotient_converter.sv
`default_nettype none
// ============================================================================
// Module   : otf_quotient_converter
// Brief    : On-the-fly conversion of a signed-digit quotient stream to an
//            (N+1)-bit two's-complement fraction, with valid/ack output hold.
//            Optional guard digit (floor rounding) via OTF_GUARD_DIGIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module otf_quotient_converter #(
  parameter int N     = 8,
  parameter int DELTA = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       digit_valid,
  input  logic [1:0] q_digit,
  input  logic       out_ack,
  output logic [N:0] q_out,
  output logic       q_valid,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_skip = 2'd1;
  localparam logic [1:0] c_conv = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  localparam int c_cw = $clog2(N + DELTA + 2);
`ifdef OTF_GUARD_DIGIT_EN
  localparam int c_conv_digits = N + 1;
`else
  localparam int c_conv_digits = N;
`endif
  localparam logic [c_cw-1:0] c_skip_last = c_cw'((DELTA > 0) ? DELTA - 1 : 0);
  localparam logic [c_cw-1:0] c_conv_last = c_cw'(c_conv_digits - 1);

  logic [1:0]      r_state;
  logic [c_cw-1:0] r_cnt;
  logic [N:0]      r_q;
  logic [N:0]      r_qm;
  logic [N:0]      r_q_out;
  logic            r_q_valid;
  logic            r_err;

  logic [N:0]      w_q_nxt;
  logic [N:0]      w_qm_nxt;
  logic            w_illegal;

  assign w_illegal = (q_digit == 2'b11);

  // Q and QM are both kept so a -1 digit never needs a borrow chain.
  always_comb begin
    w_q_nxt  = {r_q[N-1:0], 1'b0};
    w_qm_nxt = {r_qm[N-1:0], 1'b1};
    case (q_digit)
      2'b10: begin
        w_q_nxt  = {r_q[N-1:0], 1'b1};
        w_qm_nxt = {r_q[N-1:0], 1'b0};
      end
      2'b01: begin
        w_q_nxt  = {r_qm[N-1:0], 1'b1};
        w_qm_nxt = {r_qm[N-1:0], 1'b0};
      end
      default: begin
        w_q_nxt  = {r_q[N-1:0], 1'b0};
        w_qm_nxt = {r_qm[N-1:0], 1'b1};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_q       <= '0;
      r_qm      <= '1;
      r_q_out   <= '0;
      r_q_valid <= 1'b0;
      r_err     <= 1'b0;
    end else if (start) begin
      r_state   <= (DELTA == 0) ? c_conv : c_skip;
      r_cnt     <= '0;
      r_q       <= '0;
      r_qm      <= '1;
      r_q_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        c_skip: begin
          if (digit_valid) begin
            if (r_cnt == c_skip_last) begin
              r_cnt   <= '0;
              r_state <= c_conv;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_conv: begin
          if (digit_valid) begin
            if (w_illegal) r_err <= 1'b1;
            r_q  <= w_q_nxt;
            r_qm <= w_qm_nxt;
            if (r_cnt == c_conv_last) begin
`ifdef OTF_GUARD_DIGIT_EN
              // Guard -1 means the full value sits just below Q_N: floor is QM_N.
              r_q_out <= (q_digit == 2'b01) ? r_qm : r_q;
`else
              r_q_out <= w_q_nxt;
`endif
              r_q_valid <= 1'b1;
              r_cnt     <= '0;
              r_state   <= c_done;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_done: begin
          if (out_ack) begin
            r_q_valid <= 1'b0;
            r_state   <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign q_out   = r_q_out;
  assign q_valid = r_q_valid;
  assign busy    = (r_state == c_skip) || (r_state == c_conv);
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_otf_quotient_converter.sv
`default_nettype none
// Testbench for otf_quotient_converter: directed and randomized digit streams
// checked against an arithmetic (sum of digit weights) reference model.
module tb_otf_quotient_converter;

  localparam int N     = 8;
  localparam int DELTA = 2;
`ifdef OTF_GUARD_DIGIT_EN
  localparam int ND = N + 1;
`else
  localparam int ND = N;
`endif
  localparam logic [1:0] P = 2'b10, M = 2'b01, Z = 2'b00, X = 2'b11;

  typedef logic [1:0] dvec_t [ND];
  typedef logic [N:0] res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       digit_valid = 1'b0;
  logic [1:0] q_digit = 2'b00;
  logic       out_ack = 1'b0;
  logic [N:0] q_out;
  logic       q_valid;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  otf_quotient_converter #(.N(N), .DELTA(DELTA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid),
    .q_digit(q_digit), .out_ack(out_ack), .q_out(q_out), .q_valid(q_valid),
    .busy(busy), .err(err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int dval(input logic [1:0] d);
    return (d == P) ? 1 : (d == M) ? -1 : 0;
  endfunction

  // Reference: value = sum d_i * 2^(N-1-i); guard -1 floors one LSB down.
  function automatic res_t model(input dvec_t d);
    int v = 0;
    for (int i = 0; i < N; i++) v = 2 * v + dval(d[i]);
    if (ND > N && d[ND-1] == M) v = v - 1;
    return res_t'(v);
  endfunction

  function automatic logic [1:0] rnd_digit();
    case ($urandom_range(0, 2))
      0: return P;
      1: return M;
      default: return Z;
    endcase
  endfunction

  task automatic send(input logic [1:0] d);
    digit_valid = 1'b1;
    q_digit = d;
    @(negedge clk);
    digit_valid = 1'b0;
    q_digit = 2'b00;
  endtask

  task automatic begin_conv();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DELTA; i++) send(rnd_digit());
  endtask

  task automatic feed(input dvec_t d, input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      send(d[i]);
      if (i < ND - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({q_out, q_valid, busy, err} !== '0) begin
      failures++;
      $display("FAIL reset: q_out=%h q_valid=%b busy=%b err=%b, required all 0", q_out, q_valid, busy, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    res_t exp_tab [4] = '{9'h040, 9'h180, 9'h0FF, 9'h101};
    for (int k = 0; k < 4; k++) begin
      dvec_t d;
      for (int i = 0; i < ND; i++) d[i] = Z;
      case (k)
        0: begin d[0] = P; d[1] = M; end
        1: d[0] = M;
        2: for (int i = 0; i < N; i++) d[i] = P;
        default: for (int i = 0; i < N; i++) d[i] = M;
      endcase
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_after_start case %0d: busy=%b, required 1", k, busy);
      end
      for (int i = 0; i < DELTA; i++) send(rnd_digit());
      feed(d, 0, ND - 1, 0);
      checks++;
      if (q_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL early_valid case %0d: q_valid=%b busy=%b, required 0/1", k, q_valid, busy);
      end
      send(d[ND-1]);
      checks++;
      if (q_valid !== 1'b1 || busy !== 1'b0 || q_out !== exp_tab[k] || err !== 1'b0) begin
        failures++;
        $display("FAIL directed case %0d: q_out=%h q_valid=%b busy=%b err=%b, required %h/1/0/0",
                 k, q_out, q_valid, busy, err, exp_tab[k]);
      end
      ack();
      checks++;
      if (q_valid !== 1'b0) begin
        failures++;
        $display("FAIL ack_clear case %0d: q_valid=%b, required 0", k, q_valid);
      end
    end
  endtask

  task automatic test_gaps();
    dvec_t d;
    for (int i = 0; i < ND; i++) d[i] = Z;
    d[0] = P; d[1] = M;
    begin_conv();
    feed(d, 0, ND - 1, 3);
    checks++;
    if (q_valid !== 1'b0) begin
      failures++;
      $display("FAIL gaps_early: q_valid=%b, required 0", q_valid);
    end
    send(d[ND-1]);
    checks++;
    if (q_valid !== 1'b1 || q_out !== 9'h040) begin
      failures++;
      $display("FAIL gaps: q_out=%h q_valid=%b, required 040/1", q_out, q_valid);
    end
    ack();
  endtask

  task automatic test_illegal();
    dvec_t d;
    for (int i = 0; i < ND; i++) d[i] = Z;
    d[3] = X;
    begin_conv();
    feed(d, 0, ND, 0);
    checks++;
    if (q_valid !== 1'b1 || q_out !== 9'h000 || err !== 1'b1) begin
      failures++;
      $display("FAIL illegal: q_out=%h q_valid=%b err=%b, required 000/1/1", q_out, q_valid, err);
    end
    ack();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b, required 0", err);
    end
    for (int i = 0; i < DELTA; i++) send(Z);
    feed(d, 0, ND, 0);
    ack();
  endtask

  task automatic test_abort_and_hold();
    dvec_t d;
    dvec_t j;
    for (int i = 0; i < ND; i++) begin d[i] = Z; j[i] = rnd_digit(); end
    d[0] = P; d[1] = M;
    begin_conv();
    feed(j, 0, 5, 0);
    begin_conv();
    feed(d, 0, ND - 1, 0);
    checks++;
    if (q_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_valid: q_valid=%b busy=%b, required 0/1", q_valid, busy);
    end
    send(d[ND-1]);
    checks++;
    if (q_valid !== 1'b1 || q_out !== 9'h040) begin
      failures++;
      $display("FAIL abort_result: q_out=%h q_valid=%b, required 040/1", q_out, q_valid);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (q_valid !== 1'b1 || q_out !== 9'h040) begin
        failures++;
        $display("FAIL hold cycle %0d: q_out=%h q_valid=%b, required 040/1", c, q_out, q_valid);
      end
    end
    ack();
  endtask

  task automatic test_start_with_digit();
    dvec_t d;
    for (int i = 0; i < ND; i++) d[i] = Z;
    d[0] = P; d[1] = M;
    start = 1'b1; digit_valid = 1'b1; q_digit = P;
    @(negedge clk);
    start = 1'b0; digit_valid = 1'b0; q_digit = Z;
    for (int i = 0; i < DELTA; i++) send(Z);
    feed(d, 0, ND, 0);
    checks++;
    if (q_valid !== 1'b1 || q_out !== 9'h040) begin
      failures++;
      $display("FAIL start_with_digit: q_out=%h q_valid=%b, required 040/1", q_out, q_valid);
    end
    // start together with ack in DONE restarts immediately
    start = 1'b1; out_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ack = 1'b0;
    checks++;
    if (q_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_with_ack: q_valid=%b busy=%b, required 0/1", q_valid, busy);
    end
    for (int i = 0; i < ND; i++) d[i] = rnd_digit();
    for (int i = 0; i < DELTA; i++) send(rnd_digit());
    feed(d, 0, ND, 0);
    checks++;
    if (q_valid !== 1'b1 || q_out !== model(d)) begin
      failures++;
      $display("FAIL restart_result: q_out=%h q_valid=%b, required %h/1", q_out, q_valid, model(d));
    end
    ack();
  endtask

  task automatic test_async_reset();
    begin_conv();
    send(P);
    send(X);
    send(M);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q_out, q_valid, busy, err} !== '0) begin
      failures++;
      $display("FAIL async_reset: q_out=%h q_valid=%b busy=%b err=%b, required all 0", q_out, q_valid, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      dvec_t d;
      int gap;
      for (int i = 0; i < ND; i++) d[i] = rnd_digit();
      gap = int'($urandom_range(0, 2));
      begin_conv();
      feed(d, 0, ND, gap);
      checks++;
      if (q_valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || q_out !== model(d)) begin
        failures++;
        $display("FAIL random iter %0d: q_out=%h q_valid=%b busy=%b err=%b, required %h/1/0/0",
                 it, q_out, q_valid, busy, err, model(d));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack();
    end
  endtask

`ifdef OTF_GUARD_DIGIT_EN
  task automatic test_guard();
    for (int k = 0; k < 2; k++) begin
      dvec_t d;
      res_t exp_val;
      for (int i = 0; i < ND; i++) d[i] = Z;
      d[0] = P;
      d[N] = (k == 0) ? M : P;
      exp_val = (k == 0) ? 9'h07F : 9'h080;
      begin_conv();
      feed(d, 0, ND, 0);
      checks++;
      if (q_valid !== 1'b1 || q_out !== exp_val) begin
        failures++;
        $display("FAIL guard case %0d: q_out=%h q_valid=%b, required %h/1", k, q_out, q_valid, exp_val);
      end
      ack();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_illegal();
    test_abort_and_hold();
    test_start_with_digit();
    test_async_reset();
    test_random();
`ifdef OTF_GUARD_DIGIT_EN
    test_guard();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
